timer_counter_pg: RTL and testbench

Parametrised successor to the team's two-word 64-bit timer counter. It adds a configurable width, an up/down direction, a power-of-two prescaler, a debug halt and a compare register with a sticky match interrupt and optional auto-reload. It sits inside the timer IP between the register-file decode, which supplies the word write selects and control bits, and the interrupt aggregator.

---
 rtl/timer_counter_pg.sv | 157 +++++++++++++++
 tb/tb_timer_counter_pg.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter_pg.sv
// timer_counter_pg
//   Parametrised free-running / compare timer with up/down direction, a
//   power-of-two prescaler, debug halt, 32-bit word access for the counter
//   and compare registers, and a sticky compare-match interrupt with
//   optional auto-reload on the terminal count.
//
// Parameters
//   CNT_W  counter/compare width, multiple of 32 in 32..128
//   PRE_W  prescaler width; divide ratio is 2^min(div_val, PRE_W)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   wdata               32-bit write data for any selected word
//   cnt_wr_sel          per-word write select for the counter
//   cmp_wr_sel          per-word write select for the compare register
//   count_clr           clears counter and prescaler
//   cnt_en, halt        counting enable, debug freeze
//   mode_down           0 = up, 1 = down
//   auto_rld            reload on terminal count (cmp when up, 0 when down)
//   div_en, div_val     prescaler enable and exponent
//   int_en, int_clr     interrupt enable, sticky status clear
//   cnt, cmp            register values
//   int_st, int_out     sticky match status, gated interrupt
//   tick                combinational count-step strobe
module timer_counter_pg #(
    parameter int CNT_W = 64,
    parameter int PRE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           wdata,
    input  logic [CNT_W/32-1:0]   cnt_wr_sel,
    input  logic [CNT_W/32-1:0]   cmp_wr_sel,
    input  logic                  count_clr,
    input  logic                  cnt_en,
    input  logic                  halt,
    input  logic                  mode_down,
    input  logic                  auto_rld,
    input  logic                  div_en,
    input  logic [3:0]            div_val,
    input  logic                  int_en,
    input  logic                  int_clr,
    output logic [CNT_W-1:0]      cnt,
    output logic [CNT_W-1:0]      cmp,
    output logic                  int_st,
    output logic                  int_out,
    output logic                  tick
);

    localparam int NW = CNT_W / 32;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PRE_W:0]   PRE_ONE = {{PRE_W{1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0] PRE_INC = {{(PRE_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cmp_reg, cmp_next;
    logic [CNT_W-1:0] cnt_wr_val, cmp_wr_val, cnt_step;
    logic [PRE_W-1:0] pre_reg, pre_next, pre_term;
    logic [PRE_W:0]   pre_term_wide;
    logic [31:0]      div_eff;
    logic             int_st_reg, int_st_next;
    logic             run, match;

    assign run   = cnt_en & ~halt;
    assign match = (cnt_reg == cmp_reg);

    // Exponents beyond the prescaler width saturate to the full range.
    assign div_eff = ({28'd0, div_val} > 32'(PRE_W)) ? 32'(PRE_W) : {28'd0, div_val};

    // Terminal prescaler value 2^div_eff - 1, computed one bit wider so the
    // saturated case yields all-ones in the low PRE_W bits.
    assign pre_term_wide = (PRE_ONE << div_eff) - PRE_ONE;
    assign pre_term      = pre_term_wide[PRE_W-1:0];

    assign tick = run & (~div_en | (pre_reg == pre_term));

    // Word-merge of write data: unselected words keep their current value.
    genvar gi;
    generate
        for (gi = 0; gi < NW; gi++) begin : g_word
            assign cnt_wr_val[32*gi +: 32] = cnt_wr_sel[gi] ? wdata : cnt_reg[32*gi +: 32];
            assign cmp_wr_val[32*gi +: 32] = cmp_wr_sel[gi] ? wdata : cmp_reg[32*gi +: 32];
        end
    endgenerate

    // One count step, including the auto-reload terminal cases.
    always_comb begin
        cnt_step = cnt_reg;
        if (!mode_down) begin
            if (auto_rld && match) begin
                cnt_step = '0;
            end else begin
                cnt_step = cnt_reg + CNT_ONE;
            end
        end else begin
            if (auto_rld && (cnt_reg == '0)) begin
                cnt_step = cmp_reg;
            end else begin
                cnt_step = cnt_reg - CNT_ONE;
            end
        end
    end

    always_comb begin
        // Counter: clear beats write, write beats (and discards) a step.
        cnt_next = cnt_reg;
        if (count_clr) begin
            cnt_next = '0;
        end else if (|cnt_wr_sel) begin
            cnt_next = cnt_wr_val;
        end else if (tick) begin
            cnt_next = cnt_step;
        end

        cmp_next = cmp_wr_val;

        // Prescaler advances independently of counter writes.
        pre_next = pre_reg;
        if (!cnt_en || !div_en || count_clr) begin
            pre_next = '0;
        end else if (halt) begin
            pre_next = pre_reg;
        end else if (tick) begin
            pre_next = '0;
        end else begin
            pre_next = pre_reg + PRE_INC;
        end

        // Sticky status: a new match wins over a simultaneous clear.
        int_st_next = int_st_reg;
        if (match) begin
            int_st_next = 1'b1;
        end else if (int_clr) begin
            int_st_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            cmp_reg    <= '1;
            pre_reg    <= '0;
            int_st_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            cmp_reg    <= cmp_next;
            pre_reg    <= pre_next;
            int_st_reg <= int_st_next;
        end
    end

    assign cnt     = cnt_reg;
    assign cmp     = cmp_reg;
    assign int_st  = int_st_reg;
    assign int_out = int_st_reg & int_en;

endmodule

// File: tb/tb_timer_counter_pg.sv
module tb_timer_counter_pg;

    localparam int CNT_W = 64;
    localparam int PRE_W = 8;
    localparam int NW    = CNT_W / 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, count_clr, cnt_en, halt, mode_down, auto_rld;
    logic             div_en, int_en, int_clr;
    logic [31:0]      wdata;
    logic [NW-1:0]    cnt_wr_sel, cmp_wr_sel;
    logic [3:0]       div_val;
    logic [CNT_W-1:0] cnt, cmp;
    logic             int_st, int_out, tick;

    int total = 0;
    int bad   = 0;

    // Reference state: counter value, compare value, sticky flag and the
    // number of run cycles elapsed in the current prescaler period.
    logic [63:0] m_cnt   = 64'd0;
    logic [63:0] m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    logic        m_int   = 1'b0;
    int          m_phase = 0;
    bit          chk_on  = 1'b0;

    timer_counter_pg #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk(clk), .rst(rst), .wdata(wdata),
        .cnt_wr_sel(cnt_wr_sel), .cmp_wr_sel(cmp_wr_sel),
        .count_clr(count_clr), .cnt_en(cnt_en), .halt(halt),
        .mode_down(mode_down), .auto_rld(auto_rld), .div_en(div_en),
        .div_val(div_val), .int_en(int_en), .int_clr(int_clr),
        .cnt(cnt), .cmp(cmp), .int_st(int_st), .int_out(int_out), .tick(tick)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_tick();
        int period;
        period = 1 << ((int'(div_val) > PRE_W) ? PRE_W : int'(div_val));
        if (!(cnt_en && !halt)) return 1'b0;
        if (!div_en) return 1'b1;
        return (m_phase == period - 1);
    endfunction

    // One clock: compare DUT against the model, then advance both.
    task automatic cycle();
        logic [63:0] n_cnt, n_cmp;
        logic        n_int, t;
        int          n_phase;
        #1;
        t = model_tick();
        if (chk_on) begin
            chk("tick",    tick,    t);
            chk("cnt",     cnt,     m_cnt);
            chk("cmp",     cmp,     m_cmp);
            chk("int_st",  int_st,  m_int);
            chk("int_out", int_out, m_int & int_en);
        end

        if (rst || !cnt_en || !div_en || count_clr) n_phase = 0;
        else if (halt)                              n_phase = m_phase;
        else if (t)                                 n_phase = 0;
        else                                        n_phase = m_phase + 1;

        n_cnt = m_cnt;
        if (rst || count_clr) begin
            n_cnt = 64'd0;
        end else if (cnt_wr_sel != '0) begin
            for (int i = 0; i < NW; i++) if (cnt_wr_sel[i]) n_cnt[32*i +: 32] = wdata;
        end else if (t) begin
            if (!mode_down) n_cnt = (auto_rld && m_cnt == m_cmp) ? 64'd0 : m_cnt + 64'd1;
            else            n_cnt = (auto_rld && m_cnt == 64'd0) ? m_cmp : m_cnt - 64'd1;
        end

        n_cmp = m_cmp;
        for (int i = 0; i < NW; i++) if (cmp_wr_sel[i]) n_cmp[32*i +: 32] = wdata;
        if (rst) n_cmp = 64'hFFFF_FFFF_FFFF_FFFF;

        if (rst)                 n_int = 1'b0;
        else if (m_cnt == m_cmp) n_int = 1'b1;
        else if (int_clr)        n_int = 1'b0;
        else                     n_int = m_int;

        @(posedge clk);
        #1;
        m_cnt   = n_cnt;
        m_cmp   = n_cmp;
        m_int   = n_int;
        m_phase = n_phase;
        chk_on  = 1'b1;
    endtask

    task automatic idle();
        rst = 1'b0; count_clr = 1'b0; cnt_en = 1'b0; halt = 1'b0;
        mode_down = 1'b0; auto_rld = 1'b0; div_en = 1'b0; div_val = 4'd0;
        int_en = 1'b0; int_clr = 1'b0; wdata = 32'd0;
        cnt_wr_sel = '0; cmp_wr_sel = '0;
    endtask

    int exp_seq [5] = '{3, 2, 1, 0, 3};

    initial begin
        idle();

        // Reset and basic count
        rst = 1'b1;
        cycle();
        cycle();
        chk("rst_cnt", cnt, 64'd0);
        chk("rst_cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
        rst = 1'b0; cnt_en = 1'b1;
        repeat (5) cycle();
        chk("basic5", cnt, 64'd5);
        $display("txn reset/basic: cnt=%0d", cnt);

        // Word write and carry across the word boundary
        cnt_en = 1'b0; cnt_wr_sel = 2'b01; wdata = 32'hFFFF_FFFF;
        cycle();
        cnt_wr_sel = 2'b10; wdata = 32'h0000_0001;
        cycle();
        cnt_wr_sel = '0; cnt_en = 1'b1;
        cycle();
        chk("carry", cnt, 64'h0000_0002_0000_0000);
        cnt_wr_sel = 2'b11; wdata = 32'h1234_5678;
        cycle();
        chk("wr_tick", cnt, 64'h1234_5678_1234_5678);
        cnt_wr_sel = '0; cnt_en = 1'b0;
        $display("txn word write: cnt=%h", cnt);

        // Prescaler divide by 8, then a 5-cycle halt mid-period
        count_clr = 1'b1;
        cycle();
        count_clr = 1'b0; div_en = 1'b1; div_val = 4'd3; cnt_en = 1'b1;
        repeat (32) cycle();
        chk("pre32", cnt, 64'd4);
        repeat (3) cycle();
        halt = 1'b1;
        repeat (5) cycle();
        halt = 1'b0;
        repeat (4) cycle();
        chk("halt_late", cnt, 64'd4);
        cycle();
        chk("halt_tick", cnt, 64'd5);
        $display("txn prescaler: cnt=%0d", cnt);

        // Down count wrap
        cnt_en = 1'b0; div_en = 1'b0; count_clr = 1'b1;
        cycle();
        count_clr = 1'b0; cnt_wr_sel = 2'b01; wdata = 32'd1;
        cycle();
        cnt_wr_sel = '0; mode_down = 1'b1; cnt_en = 1'b1;
        cycle();
        chk("down0", cnt, 64'd0);
        cycle();
        chk("down_wrap", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        cnt_en = 1'b0;
        $display("txn down wrap: cnt=%h", cnt);

        // Compare, auto-reload and sticky interrupt
        cmp_wr_sel = 2'b01; wdata = 32'd9; count_clr = 1'b1;
        cycle();
        cmp_wr_sel = 2'b10; wdata = 32'd0; count_clr = 1'b0;
        cycle();
        cmp_wr_sel = '0; int_clr = 1'b1;
        cycle();
        int_clr = 1'b0;
        chk("int_cleared", int_st, 1'b0);
        mode_down = 1'b0; auto_rld = 1'b1; cnt_en = 1'b1; int_en = 1'b0;
        repeat (9) cycle();
        chk("seq9", cnt, 64'd9);
        chk("int_pre", int_st, 1'b0);
        cycle();
        chk("reload0", cnt, 64'd0);
        chk("int_set", int_st, 1'b1);
        chk("int_masked", int_out, 1'b0);
        int_en = 1'b1;
        #1;
        chk("int_out_en", int_out, 1'b1);
        repeat (9) cycle();
        chk("seq9b", cnt, 64'd9);
        int_clr = 1'b1;
        cycle();
        int_clr = 1'b0;
        chk("set_wins", int_st, 1'b1);
        $display("txn compare/reload: int_st=%0b", int_st);

        // Down reload from 0 to cmp
        cnt_en = 1'b0; int_en = 1'b0; cmp_wr_sel = 2'b01; wdata = 32'd3; count_clr = 1'b1;
        cycle();
        cmp_wr_sel = '0; count_clr = 1'b0; mode_down = 1'b1; cnt_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("down_rld", cnt, 64'(exp_seq[i]));
        end
        $display("txn down reload: cnt=%0d", cnt);

        // count_clr together with a write and a tick clears cnt and pre
        div_en = 1'b1; div_val = 4'd2;
        repeat (2) cycle();
        count_clr = 1'b1; cnt_wr_sel = 2'b11; wdata = 32'hAAAA_AAAA;
        cycle();
        count_clr = 1'b0; cnt_wr_sel = '0;
        chk("clr_pri", cnt, 64'd0);
        repeat (3) cycle();
        chk("clr_pre_hold", cnt, 64'd0);
        cycle();
        chk("clr_pre_tick", cnt, 64'd3);
        $display("txn clear priority: cnt=%0d", cnt);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 99) == 0);
            count_clr  = ($urandom_range(0, 49) == 0);
            cnt_en     = ($urandom_range(0, 7) != 0);
            halt       = ($urandom_range(0, 7) == 0);
            mode_down  = ($urandom_range(0, 3) == 0);
            auto_rld   = $urandom_range(0, 1) != 0;
            div_en     = $urandom_range(0, 1) != 0;
            div_val    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(0, 3));
            int_en     = $urandom_range(0, 1) != 0;
            int_clr    = ($urandom_range(0, 9) == 0);
            wdata      = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 20)) : $urandom;
            cnt_wr_sel = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cmp_wr_sel = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cycle();
        end
        idle();
        cycle();
        $display("txn random: 3000 cycles, cnt=%h", cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
